// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32IM divide controller: data width, the
// M-extension divide/remainder funct3 encodings, the divider FSM state enum
// and small decode/arithmetic helpers.
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN = 32;

    // M-extension divide/remainder funct3 encodings (funct3[2] = 1)
    typedef enum logic [2:0] {
        F3_DIV  = 3'b100,
        F3_DIVU = 3'b101,
        F3_REM  = 3'b110,
        F3_REMU = 3'b111
    } div_funct3_e;

    // Divider control FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } div_state_e;

    // Signed variants are DIV and REM
    function automatic logic f3_is_signed(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // Remainder variants are REM and REMU
    function automatic logic f3_is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

    // Two's-complement negation
    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rv32im_div_step.sv
// ---------------------------------------------------------------------------
// rv32im_div_step
// One combinational restoring-division iteration.
//   rem_in   : 33-bit partial remainder from the previous step
//   quot_in  : dividend/quotient shift register (MSB feeds the remainder)
//   divisor  : unsigned divisor magnitude
//   rem_out  : updated partial remainder
//   quot_out : quot_in shifted left with the new quotient bit in the LSB
// ---------------------------------------------------------------------------
module rv32im_div_step
    import rv32i_pkg::*;
(
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quot_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quot_out
);

    logic [XLEN+1:0] shifted_s;
    logic [XLEN+1:0] diff_s;
    logic            q_bit_s;

    // Shift, trial subtract, restore when the trial goes negative. The
    // shifted value is kept one bit wider than the remainder so the borrow
    // of the trial subtract is never lost, even for all-ones operands.
    always_comb begin
        shifted_s = {rem_in, quot_in[XLEN-1]};
        diff_s    = shifted_s - {2'b00, divisor};
        q_bit_s   = ~diff_s[XLEN+1];
        if (q_bit_s) begin
            rem_out = diff_s[XLEN:0];
        end else begin
            rem_out = shifted_s[XLEN:0];
        end
        quot_out = {quot_in[XLEN-2:0], q_bit_s};
    end

endmodule

// File: rtl/rv32im_div_ctrl.sv
// ---------------------------------------------------------------------------
// rv32im_div_ctrl
// Multi-cycle RV32IM DIV/DIVU/REM/REMU unit for the EX stage. One op in
// flight; restoring divider with one bit per CALC cycle, sign fix-up, then a
// one-cycle result strobe. Divide-by-zero and signed overflow complete in one
// cycle.
//
// Optional feature macro: RV32IM_DIV_CACHE_EN
//   When defined, the operands/signedness/quotient/remainder of the last
//   completed op are kept; a matching start completes in one cycle.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_start, i_funct3  op valid and funct3 (100 DIV,101 DIVU,110 REM,111 REMU)
//   i_op_a, i_op_b     dividend, divisor
//   i_flush            abort any operation; wins over i_start
//   o_stall            freeze IF/ID/EX while the divide is busy
//   o_valid            one-cycle result strobe
//   o_result           quotient/remainder, held until the next o_valid
// ---------------------------------------------------------------------------
module rv32im_div_ctrl
    import rv32i_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    div_state_e      state_r;
    div_state_e      state_next_s;
    logic [4:0]      cnt_r;
    logic [XLEN:0]   rem_r;
    logic [XLEN-1:0] quot_r;
    logic [XLEN-1:0] divisor_r;
    logic            is_rem_r;
    logic            q_neg_r;
    logic            r_neg_r;
    logic            valid_r;
    logic [XLEN-1:0] result_r;

    logic            accept_s;
    logic            op_signed_s;
    logic            op_rem_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_abs_s;
    logic [XLEN-1:0] b_abs_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic            cache_hit_s;
    logic [XLEN-1:0] cache_q_s;
    logic [XLEN-1:0] cache_r_s;
    logic            bypass_s;
    logic [XLEN-1:0] bypass_q_s;
    logic [XLEN-1:0] bypass_r_s;
    logic [XLEN:0]   step_rem_s;
    logic [XLEN-1:0] step_quot_s;
    logic [XLEN-1:0] fix_q_s;
    logic [XLEN-1:0] fix_r_s;

    assign accept_s    = (state_r == ST_IDLE) & i_start & i_funct3[2] & ~i_flush;
    assign op_signed_s = f3_is_signed(i_funct3);
    assign op_rem_s    = f3_is_rem(i_funct3);
    assign a_neg_s     = op_signed_s & i_op_a[XLEN-1];
    assign b_neg_s     = op_signed_s & i_op_b[XLEN-1];
    assign a_abs_s     = a_neg_s ? twos_neg(i_op_a) : i_op_a;
    assign b_abs_s     = b_neg_s ? twos_neg(i_op_b) : i_op_b;
    assign div_zero_s  = (i_op_b == 32'h0000_0000);
    assign ovf_s       = op_signed_s & (i_op_a == 32'h8000_0000) & (i_op_b == 32'hFFFF_FFFF);
    assign bypass_s    = div_zero_s | ovf_s | cache_hit_s;

    // Single-cycle results for the cases that skip the iterative divide
    always_comb begin
        bypass_q_s = 32'hFFFF_FFFF;
        bypass_r_s = i_op_a;
        if (div_zero_s) begin
            bypass_q_s = 32'hFFFF_FFFF;
            bypass_r_s = i_op_a;
        end else if (ovf_s) begin
            bypass_q_s = 32'h8000_0000;
            bypass_r_s = 32'h0000_0000;
        end else begin
            bypass_q_s = cache_q_s;
            bypass_r_s = cache_r_s;
        end
    end

    rv32im_div_step u_step (
        .rem_in   (rem_r),
        .quot_in  (quot_r),
        .divisor  (divisor_r),
        .rem_out  (step_rem_s),
        .quot_out (step_quot_s)
    );

    // After 32 steps rem_r < divisor, so its low 32 bits hold the magnitude
    assign fix_q_s = q_neg_r ? twos_neg(quot_r) : quot_r;
    assign fix_r_s = r_neg_r ? twos_neg(rem_r[XLEN-1:0]) : rem_r[XLEN-1:0];

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; flush overrides every transition
    always_comb begin
        state_next_s = state_r;
        if (i_flush) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_next_s = bypass_s ? ST_DONE : ST_CALC;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (cnt_r == 5'd31) begin
                        state_next_s = ST_FIXUP;
                    end else begin
                        state_next_s = ST_CALC;
                    end
                end
                ST_FIXUP: state_next_s = ST_DONE;
                ST_DONE:  state_next_s = ST_IDLE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // Stall must be combinational so the accepting cycle already freezes
    // the front end; it drops in DONE so EX advances with o_valid.
    assign o_stall = accept_s | (state_r == ST_CALC) | (state_r == ST_FIXUP);

    // Datapath: operand latch, iteration, fix-up and result/strobe registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r     <= 5'd0;
            rem_r     <= 33'h0;
            quot_r    <= 32'h0000_0000;
            divisor_r <= 32'h0000_0000;
            is_rem_r  <= 1'b0;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            valid_r   <= 1'b0;
            result_r  <= 32'h0000_0000;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r     <= 5'd0;
                        rem_r     <= 33'h0;
                        quot_r    <= a_abs_s;
                        divisor_r <= b_abs_s;
                        is_rem_r  <= op_rem_s;
                        q_neg_r   <= a_neg_s ^ b_neg_s;
                        r_neg_r   <= a_neg_s;
                        if (bypass_s) begin
                            valid_r  <= 1'b1;
                            result_r <= op_rem_s ? bypass_r_s : bypass_q_s;
                        end
                    end
                end
                ST_CALC: begin
                    if (!i_flush) begin
                        rem_r  <= step_rem_s;
                        quot_r <= step_quot_s;
                        cnt_r  <= cnt_r + 5'd1;
                    end
                end
                ST_FIXUP: begin
                    if (!i_flush) begin
                        valid_r  <= 1'b1;
                        result_r <= is_rem_r ? fix_r_s : fix_q_s;
                    end
                end
                ST_DONE: begin
                    valid_r <= 1'b0;
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid  = valid_r;
    assign o_result = result_r;

`ifdef RV32IM_DIV_CACHE_EN
    logic            cache_vld_r;
    logic            cache_sgn_r;
    logic [XLEN-1:0] cache_a_r;
    logic [XLEN-1:0] cache_b_r;
    logic [XLEN-1:0] cache_q_r;
    logic [XLEN-1:0] cache_r_r;
    logic            op_sgn_r;
    logic [XLEN-1:0] op_a_r;
    logic [XLEN-1:0] op_b_r;

    assign cache_hit_s = cache_vld_r & (cache_a_r == i_op_a) & (cache_b_r == i_op_b)
                         & (cache_sgn_r == op_signed_s);
    assign cache_q_s   = cache_q_r;
    assign cache_r_s   = cache_r_r;

    // Result cache: filled by every op that reaches DONE without a flush
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cache_vld_r <= 1'b0;
            cache_sgn_r <= 1'b0;
            cache_a_r   <= 32'h0000_0000;
            cache_b_r   <= 32'h0000_0000;
            cache_q_r   <= 32'h0000_0000;
            cache_r_r   <= 32'h0000_0000;
            op_sgn_r    <= 1'b0;
            op_a_r      <= 32'h0000_0000;
            op_b_r      <= 32'h0000_0000;
        end else if (accept_s) begin
            op_sgn_r <= op_signed_s;
            op_a_r   <= i_op_a;
            op_b_r   <= i_op_b;
            if (bypass_s) begin
                cache_vld_r <= 1'b1;
                cache_sgn_r <= op_signed_s;
                cache_a_r   <= i_op_a;
                cache_b_r   <= i_op_b;
                cache_q_r   <= bypass_q_s;
                cache_r_r   <= bypass_r_s;
            end
        end else if ((state_r == ST_FIXUP) && !i_flush) begin
            cache_vld_r <= 1'b1;
            cache_sgn_r <= op_sgn_r;
            cache_a_r   <= op_a_r;
            cache_b_r   <= op_b_r;
            cache_q_r   <= fix_q_s;
            cache_r_r   <= fix_r_s;
        end
    end
`else
    assign cache_hit_s = 1'b0;
    assign cache_q_s   = 32'h0000_0000;
    assign cache_r_s   = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_rv32im_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32im_div_ctrl
// Directed, table-driven bench for rv32im_div_ctrl plus hand-written
// sequences for flush, ignored starts and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_rv32im_div_ctrl;
    import rv32i_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        valid;
    logic [31:0] result;

    int n_chk;
    int n_fail;

    rv32im_div_ctrl dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_funct3 (funct3),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_flush  (flush),
        .o_stall  (stall),
        .o_valid  (valid),
        .o_result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

`ifdef RV32IM_DIV_CACHE_EN
    logic        m_vld;
    logic        m_sgn;
    logic [31:0] m_a;
    logic [31:0] m_b;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_signed_f3(input logic [2:0] f3);
        return (f3 == 3'b100) || (f3 == 3'b110);
    endfunction

    // Expected latency: specials and (with cache) hits finish in one cycle
    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'h0) return 1;
        if (is_signed_f3(f3) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
`ifdef RV32IM_DIV_CACHE_EN
        if (m_vld && (m_a == a) && (m_b == b) && (m_sgn == is_signed_f3(f3))) return 1;
`endif
        return 34;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef RV32IM_DIV_CACHE_EN
        m_vld = 1'b1;
        m_a   = a;
        m_b   = b;
        m_sgn = is_signed_f3(f3);
`endif
    endtask

    task automatic model_clear();
`ifdef RV32IM_DIV_CACHE_EN
        m_vld = 1'b0;
`endif
    endtask

    // Called at a negedge with the DUT idle: drives a start in cycle 0 and
    // waits (bounded) for o_valid, checking o_stall every cycle on the way.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic stall_ok);
        lat      = -1;
        res      = 32'h0;
        stall_ok = 1'b1;
        start    = 1'b1;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        #1;
        if (stall !== 1'b1) stall_ok = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                lat = k;
                res = result;
                if (stall !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) stall_ok = 1'b0;
            if (k == 1) start = 1'b0;
        end
        start = 1'b0;
    endtask

    // Drive a start that must not be accepted and confirm nothing happens
    task automatic no_accept(input string name, input logic [2:0] f3, input logic fl);
        logic saw;
        saw    = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        op_a   = 32'd50;
        op_b   = 32'd5;
        flush  = fl;
        #1;
        chk({name, "_stall"}, {31'h0, stall}, 32'h0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (valid === 1'b1) saw = 1'b1;
            @(negedge clk);
        end
        chk({name, "_no_valid"}, {31'h0, saw}, 32'h0);
    endtask

    int          lat;
    int          elat;
    logic [31:0] res;
    logic        sok;
    logic [31:0] held;
    logic        saw_valid;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_clear();
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = 32'h0;
        op_b   = 32'h0;

        vecs[0]  = '{3'b101, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{3'b111, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{3'b100, 32'd100,        32'd7,          32'd14};
        vecs[3]  = '{3'b110, 32'd100,        32'd7,          32'd2};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[6]  = '{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{3'b110, 32'd5,          32'd0,          32'd5};
        vecs[8]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[9]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
        vecs[10] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
        vecs[11] = '{3'b111, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1};
        vecs[12] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[13] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[14] = '{3'b110, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF};
        vecs[15] = '{3'b101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1};
        vecs[16] = '{3'b111, 32'h1234_5678,  32'h0000_0100,  32'h0000_0078};
        vecs[17] = '{3'b100, 32'h8000_0000,  32'd2,          32'hC000_0000};
        vecs[18] = '{3'b111, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_valid",  {31'h0, valid}, 32'h0);
        chk("reset_stall",  {31'h0, stall}, 32'h0);
        chk("reset_result", result,         32'h0);
        rst_n = 1'b1;

        // Table of single operations
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_idle_valid", i), {31'h0, valid}, 32'h0);
            elat = exp_latency(vecs[i].f3, vecs[i].a, vecs[i].b);
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, lat, res, sok);
            chk($sformatf("v%0d_result",  i), res,            vecs[i].exp);
            chk($sformatf("v%0d_latency", i), 32'(lat),       32'(elat));
            chk($sformatf("v%0d_stall",   i), {31'h0, sok},   32'h1);
            model_store(vecs[i].f3, vecs[i].a, vecs[i].b);
        end

        // Starts that must be ignored: funct3[2]=0, and start with flush
        no_accept("f3_low",      3'b001, 1'b0);
        no_accept("flush_start", 3'b101, 1'b1);

        // Flush in cycle 10 of a DIVU; new start in cycle 11
        @(negedge clk);
        held      = result;
        saw_valid = 1'b0;
        start     = 1'b1;
        funct3    = 3'b101;
        op_a      = 32'd1000;
        op_b      = 32'd10;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (valid === 1'b1) saw_valid = 1'b1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (valid === 1'b1) saw_valid = 1'b1;
        chk("flush_idle_stall", {31'h0, stall},     32'h0);
        chk("flush_no_valid",   {31'h0, saw_valid}, 32'h0);
        chk("flush_held",       result,             held);
        elat = exp_latency(3'b101, 32'd1000, 32'd10);
        do_op(3'b101, 32'd1000, 32'd10, lat, res, sok);
        chk("post_flush_result",  res,          32'd100);
        chk("post_flush_latency", 32'(lat),     32'(elat));
        chk("post_flush_stall",   {31'h0, sok}, 32'h1);
        model_store(3'b101, 32'd1000, 32'd10);

        // Reset asserted in cycle 20 of a DIV, then DIVU 9/3 right after release
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'b100;
        op_a   = 32'd100;
        op_b   = 32'd3;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        chk("mid_op_stall", {31'h0, stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid",  {31'h0, valid}, 32'h0);
        chk("rst_mid_stall",  {31'h0, stall}, 32'h0);
        chk("rst_mid_result", result,         32'h0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b101, 32'd9, 32'd3, lat, res, sok);
        chk("post_rst_result",  res,          32'd3);
        chk("post_rst_latency", 32'(lat),     32'd34);
        chk("post_rst_stall",   {31'h0, sok}, 32'h1);
        @(negedge clk);
        chk("post_rst_pulse",   {31'h0, valid}, 32'h0);
        chk("post_rst_held",    result,         32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32im_div_ctrl.md
RV32IM_DIV_CTRL -- requirements
Module: rv32im_div_ctrl

Interface
REQ-001 SHALL have ports: i_clk  in  1  clock; all state on rising edge.
REQ-002 SHALL have: i_rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: i_start  in  1  EX-stage M-extension divide/remainder op valid.
REQ-004 SHALL have: i_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]=0 ignored.
REQ-005 SHALL have: i_op_a / i_op_b  in  32 each  dividend / divisor.
REQ-006 SHALL have: i_flush  in  1  pipeline flush; aborts any operation.
REQ-007 SHALL have: o_stall  out  1  freeze IF/ID/EX while divide in progress.
REQ-008 SHALL have: o_valid  out  1  one-cycle result strobe.
REQ-009 SHALL have: o_result  out  32  quotient or remainder, held until next o_valid.

Function
REQ-010 SHALL implement FSM IDLE, CALC, FIXUP, DONE; single op in flight.
REQ-011 SHALL accept start only in IDLE with i_start=1, funct3[2]=1, i_flush=0; latch operands, op, signedness; starts elsewhere ignored.
REQ-012 Signed ops SHALL latch absolute values plus quotient sign (a^b) and remainder sign (a).
REQ-013 IDLE->CALC on accept; 5-bit counter from 0; one restoring step per CALC cycle; CALC->FIXUP when counter=31.
REQ-014 FIXUP SHALL apply two's-complement sign correction, select quotient/remainder, go DONE.
REQ-015 DONE SHALL assert o_valid for exactly one cycle, update o_result, return to IDLE.
REQ-016 Normal latency: start accepted in cycle 0 -> o_valid in cycle 34.
REQ-017 o_stall SHALL be (IDLE & accepting start) | CALC | FIXUP; 0 in DONE, so EX advances with o_valid.
REQ-018 Divisor=0 SHALL bypass to DONE: quotient 0xFFFFFFFF, remainder = i_op_a; o_valid in cycle 1.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL bypass to DONE: quotient 0x80000000, remainder 0; o_valid in cycle 1.
REQ-020 i_flush in any state SHALL force IDLE next edge, suppress o_valid, keep o_result; flush with start: flush wins.
REQ-021 Remainder and arithmetic SHALL use 33-bit partial remainder; no width loss at 0xFFFFFFFF operands.

Reset
REQ-022 Reset asserted SHALL immediately force IDLE, counter 0, o_valid 0, o_result 0, internal registers 0, cache invalid; applies mid-operation.
REQ-023 After deassertion, first start SHALL be accepted on the first rising edge.

Configuration
REQ-024 With RV32IM_DIV_CACHE_EN defined, SHALL store operands, signedness, quotient and remainder of each completed (non-flushed) op with valid bit.
REQ-025 With cache, start whose operands and signedness match a valid entry SHALL bypass to DONE with cached quotient/remainder; o_valid in cycle 1.
REQ-026 Without RV32IM_DIV_CACHE_EN, no cache storage; every non-special op takes full REQ-016 latency.

Structure
REQ-027 funct3 encodings, FSM state enum, and XLEN=32 constant SHALL live in shared package rv32i_pkg.
REQ-028 One combinational sub-module rv32im_div_step SHALL compute one restoring iteration (shifted remainder, trial subtract, quotient bit).

Verification
REQ-029 DIVU 100/7 -> o_valid cycle 34, o_result 14; REMU 100/7 -> 2; o_stall high cycles 0-33.
REQ-030 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-031 DIV 5/0 -> 0xFFFFFFFF cycle 1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 Flush at cycle 10 of DIVU -> no o_valid, IDLE cycle 11, o_result unchanged; new start cycle 11 completes normally.
REQ-033 Reset asserted at cycle 20 of DIV -> outputs zero immediately; after release, DIVU 9/3 -> 3 at cycle 34.
REQ-034 With cache: DIV 100/7 then REM 100/7 -> REM o_valid cycle 1, 2; without macro cycle 34.
